// File: rtl/ctrl_pipe_if.sv
// ID-stage inputs and per-stage control bundles/destinations of the control pipe.
// master drives the ID side (fetch/testbench); slave is the control pipe itself.
interface ctrl_pipe_if #(
  parameter int RF_ADDR_W = 5
);
  logic                 id_valid;
  logic [31:0]          id_instr;
  logic                 stall;
  logic                 flush;
  logic                 hazard;
  logic [12:0]          ex_ctrl;
  logic [RF_ADDR_W-1:0] ex_rd;
  logic [12:0]          mem_ctrl;
  logic [RF_ADDR_W-1:0] mem_rd;
  logic [12:0]          wb_ctrl;
  logic [RF_ADDR_W-1:0] wb_rd;
  logic                 illegal;

  modport master (
    output id_valid, id_instr, stall, flush,
    input  hazard, ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd, illegal
  );

  modport slave (
    input  id_valid, id_instr, stall, flush,
    output hazard, ex_ctrl, ex_rd, mem_ctrl, mem_rd, wb_ctrl, wb_rd, illegal
  );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// RV32 decode + ID/EX, MEM_LAT-deep MEM and WB control registers with load-use detection; 1 cycle to EX, 1+MEM_LAT to WB.
// Downstream stages never stall; ILLEGAL_TRAP_EN (optional macro) adds the registered illegal-opcode flag.
module ctrl_pipe_unit #(
  parameter int MEM_LAT   = 1,
  parameter int RF_ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_pipe_if.slave pipe
);

  typedef struct packed {
    logic       jalr;
    logic       lui;
    logic [1:0] aj;
    logic       i_type;
    logic       alusrc;
    logic [1:0] aluop;
    logic       memtoreg;
    logic       memwrite;
    logic       memread;
    logic       branch;
    logic       regwrite;
  } ctrl_t;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  ctrl_t    dec_ctrl;
  rf_addr_t dec_rd;
  rf_addr_t rs1;
  rf_addr_t rs2;
  logic     use_rs1;
  logic     use_rs2;
  logic     haz;
  logic     unused_instr;

  ctrl_t    ex_ctrl_d;
  ctrl_t    ex_ctrl_q;
  rf_addr_t ex_rd_d;
  rf_addr_t ex_rd_q;
  ctrl_t    mem_ctrl_q [MEM_LAT];
  rf_addr_t mem_rd_q   [MEM_LAT];

  assign rs1          = pipe.id_instr[15 +: RF_ADDR_W];
  assign rs2          = pipe.id_instr[20 +: RF_ADDR_W];
  assign unused_instr = ^pipe.id_instr;

  always_comb begin
    dec_ctrl = '0;
    use_rs1  = 1'b1;
    use_rs2  = 1'b0;
    case (pipe.id_instr[6:0])
      OP_R: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.aluop    = 2'b10;
        use_rs2           = 1'b1;
      end
      OP_LOAD: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.i_type   = 1'b1;
        dec_ctrl.memread  = 1'b1;
        dec_ctrl.memtoreg = 1'b1;
      end
      OP_STORE: begin
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.i_type   = 1'b1;
        dec_ctrl.memwrite = 1'b1;
        use_rs2           = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl.branch   = 1'b1;
        dec_ctrl.i_type   = 1'b1;
        dec_ctrl.aluop    = 2'b01;
        use_rs2           = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.i_type   = 1'b1;
        dec_ctrl.aluop    = 2'b10;
      end
      OP_JAL: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.i_type   = 1'b1;
        dec_ctrl.branch   = 1'b1;
        dec_ctrl.aluop    = 2'b11;
        use_rs1           = 1'b0;
      end
      OP_JALR: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.i_type   = 1'b1;
        dec_ctrl.jalr     = 1'b1;
        dec_ctrl.aj       = 2'b01;
        dec_ctrl.aluop    = 2'b11;
      end
      OP_AUIPC: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.i_type   = 1'b1;
        dec_ctrl.aj       = 2'b11;
        use_rs1           = 1'b0;
      end
      OP_LUI: begin
        dec_ctrl.regwrite = 1'b1;
        dec_ctrl.alusrc   = 1'b1;
        dec_ctrl.lui      = 1'b1;
        dec_ctrl.aluop    = 2'b10;
        use_rs1           = 1'b0;
      end
      default: dec_ctrl = '0;
    endcase
  end

  // Instructions that do not write the register file carry rd=0 so they can never trigger a hazard.
  assign dec_rd = dec_ctrl.regwrite ? pipe.id_instr[7 +: RF_ADDR_W] : '0;

  function automatic logic load_hit(ctrl_t c, rf_addr_t rd, rf_addr_t s1, rf_addr_t s2,
                                    logic u1, logic u2);
    return c.memread && (rd != '0) && ((u1 && (rd == s1)) || (u2 && (rd == s2)));
  endfunction

  // Load data is only usable once it leaves the last MEM stage, so the final stage is not checked.
  always_comb begin
    haz = 1'b0;
    if (pipe.id_valid) begin
      haz = load_hit(ex_ctrl_q, ex_rd_q, rs1, rs2, use_rs1, use_rs2);
      for (int k = 0; k < MEM_LAT - 1; k++) begin
        haz = haz | load_hit(mem_ctrl_q[k], mem_rd_q[k], rs1, rs2, use_rs1, use_rs2);
      end
    end
  end

  always_comb begin
    ex_ctrl_d = '0;
    ex_rd_d   = '0;
    if (pipe.id_valid && !pipe.flush && !pipe.stall && !haz) begin
      ex_ctrl_d = dec_ctrl;
      ex_rd_d   = dec_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q <= '0;
      ex_rd_q   <= '0;
      for (int k = 0; k < MEM_LAT; k++) begin
        mem_ctrl_q[k] <= '0;
        mem_rd_q[k]   <= '0;
      end
    end else begin
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rd_q       <= ex_rd_d;
      mem_ctrl_q[0] <= ex_ctrl_q;
      mem_rd_q[0]   <= ex_rd_q;
      for (int k = 1; k < MEM_LAT; k++) begin
        mem_ctrl_q[k] <= mem_ctrl_q[k-1];
        mem_rd_q[k]   <= mem_rd_q[k-1];
      end
    end
  end

  assign pipe.hazard   = haz;
  assign pipe.ex_ctrl  = ex_ctrl_q;
  assign pipe.ex_rd    = ex_rd_q;
  assign pipe.mem_ctrl = mem_ctrl_q[0];
  assign pipe.mem_rd   = mem_rd_q[0];
  assign pipe.wb_ctrl  = mem_ctrl_q[MEM_LAT-1];
  assign pipe.wb_rd    = mem_rd_q[MEM_LAT-1];

`ifdef ILLEGAL_TRAP_EN
  logic illegal_d;
  logic illegal_q;

  // Every legal opcode decodes to a non-empty bundle, so an all-zero decode marks an illegal one.
  assign illegal_d = pipe.id_valid && !pipe.flush && !pipe.stall && !haz && (dec_ctrl == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign pipe.illegal = illegal_q;
`else
  assign pipe.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: MEM_LAT=1 and MEM_LAT=3 instances share stimulus and are checked against a history model.
module tb_ctrl_pipe_unit;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [31:0] ADD3  = 32'h002081B3;  // add  x3,x1,x2
  localparam logic [31:0] ADD6  = 32'h00228333;  // add  x6,x5,x2
  localparam logic [31:0] ADD60 = 32'h00200333;  // add  x6,x0,x2
  localparam logic [31:0] LW5   = 32'h0000A283;  // lw   x5,0(x1)
  localparam logic [31:0] LW0   = 32'h0000A003;  // lw   x0,0(x1)
  localparam logic [31:0] JALR1 = 32'h000100E7;  // jalr x1,0(x2)
  localparam logic [31:0] ILL7F = 32'h0000007F;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ctrl_pipe_if #(.RF_ADDR_W(5)) bus1 ();
  ctrl_pipe_if #(.RF_ADDR_W(5)) bus3 ();

  ctrl_pipe_unit #(.MEM_LAT(1), .RF_ADDR_W(5)) dut1 (.clk(clk), .rst_n(rst_n), .pipe(bus1));
  ctrl_pipe_unit #(.MEM_LAT(3), .RF_ADDR_W(5)) dut3 (.clk(clk), .rst_n(rst_n), .pipe(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0 is ID/EX, index k is MEM stage k; wb is index MEM_LAT.
  logic [12:0] hc [2][4];
  logic [4:0]  hr [2][4];
  logic        exp_ill [2];
  logic        cur_v, cur_st, cur_fl;
  logic [31:0] cur_ins;

  logic [12:0] obs_ex [2], obs_mem [2], obs_wb [2];
  logic [4:0]  obs_exrd [2], obs_memrd [2], obs_wbrd [2];
  logic        obs_ill [2], obs_haz [2];

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [12:0] ref_decode(logic [31:0] ins);
    logic [12:0] rw, br, mr, mw, mtr, a10, a01, a11, src, ity, aj01, aj11, lu, jr;
    rw = 13'h001; br = 13'h002; mr = 13'h004; mw = 13'h008; mtr = 13'h010;
    a01 = 13'h020; a10 = 13'h040; a11 = 13'h060; src = 13'h080; ity = 13'h100;
    aj01 = 13'h200; aj11 = 13'h600; lu = 13'h800; jr = 13'h1000;
    case (ins[6:0])
      7'b0110011: return rw | a10;
      7'b0000011: return rw | src | ity | mr | mtr;
      7'b0100011: return src | ity | mw;
      7'b1100011: return br | ity | a01;
      7'b0010011: return rw | src | ity | a10;
      7'b1101111: return rw | src | ity | br | a11;
      7'b1100111: return rw | src | ity | jr | aj01 | a11;
      7'b0010111: return rw | src | ity | aj11;
      7'b0110111: return rw | src | lu | a10;
      default:    return 13'h0;
    endcase
  endfunction

  function automatic logic ref_haz(int d, logic v, logic [31:0] ins);
    logic u1, u2;
    u1 = !(ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (!v) return 1'b0;
    for (int j = 0; j < lat_of(d); j++) begin
      if (hc[d][j][2] && hr[d][j] != 5'd0 &&
          ((u1 && hr[d][j] == ins[19:15]) || (u2 && hr[d][j] == ins[24:20])))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 4; j++) begin
        hc[d][j] = 13'h0;
        hr[d][j] = 5'd0;
      end
      exp_ill[d] = 1'b0;
    end
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic st, logic fl);
    cur_v = v; cur_ins = ins; cur_st = st; cur_fl = fl;
    bus1.id_valid = v; bus1.id_instr = ins; bus1.stall = st; bus1.flush = fl;
    bus3.id_valid = v; bus3.id_instr = ins; bus3.stall = st; bus3.flush = fl;
    #1;
  endtask

  task automatic snap();
    obs_ex[0] = bus1.ex_ctrl;  obs_exrd[0] = bus1.ex_rd;  obs_mem[0] = bus1.mem_ctrl;
    obs_memrd[0] = bus1.mem_rd; obs_wb[0] = bus1.wb_ctrl; obs_wbrd[0] = bus1.wb_rd;
    obs_ill[0] = bus1.illegal; obs_haz[0] = bus1.hazard;
    obs_ex[1] = bus3.ex_ctrl;  obs_exrd[1] = bus3.ex_rd;  obs_mem[1] = bus3.mem_ctrl;
    obs_memrd[1] = bus3.mem_rd; obs_wb[1] = bus3.wb_ctrl; obs_wbrd[1] = bus3.wb_rd;
    obs_ill[1] = bus3.illegal; obs_haz[1] = bus3.hazard;
  endtask

  task automatic clk_step();
    logic [12:0] nc [2];
    logic [4:0]  nr [2];
    logic        ni [2];
    logic        h;
    for (int d = 0; d < 2; d++) begin
      h = ref_haz(d, cur_v, cur_ins);
      nc[d] = 13'h0;
      nr[d] = 5'd0;
      if (cur_v && !cur_fl && !cur_st && !h) begin
        nc[d] = ref_decode(cur_ins);
        nr[d] = nc[d][0] ? cur_ins[11:7] : 5'd0;
      end
      ni[d] = TRAP && cur_v && !cur_fl && !cur_st && !h && (ref_decode(cur_ins) == 13'h0);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int j = 3; j > 0; j--) begin
        hc[d][j] = hc[d][j-1];
        hr[d][j] = hr[d][j-1];
      end
      hc[d][0] = nc[d];
      hr[d][0] = nr[d];
      exp_ill[d] = ni[d];
    end
    #1;
    snap();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    drive(1'b1, ADD6, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    snap();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h0 || obs_exrd[d] !== 5'd0) begin n_err++; $display("FAIL reset_ex d%0d got %h/%0d want 0/0", d, obs_ex[d], obs_exrd[d]); end
      n_vec++; if (obs_mem[d] !== 13'h0 || obs_memrd[d] !== 5'd0) begin n_err++; $display("FAIL reset_mem d%0d got %h/%0d want 0/0", d, obs_mem[d], obs_memrd[d]); end
      n_vec++; if (obs_wb[d] !== 13'h0 || obs_wbrd[d] !== 5'd0) begin n_err++; $display("FAIL reset_wb d%0d got %h/%0d want 0/0", d, obs_wb[d], obs_wbrd[d]); end
      n_vec++; if (obs_ill[d] !== 1'b0 || obs_haz[d] !== 1'b0) begin n_err++; $display("FAIL reset_flags d%0d got ill=%b haz=%b want 0/0", d, obs_ill[d], obs_haz[d]); end
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_add();
    drive(1'b1, ADD3, 1'b0, 1'b0);
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h041 || obs_exrd[d] !== 5'd3) begin n_err++; $display("FAIL add_ex d%0d got %h/%0d want 041/3", d, obs_ex[d], obs_exrd[d]); end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      clk_step();
      if (c == 1) begin
        n_vec++; if (obs_mem[0] !== 13'h041 || obs_wb[0] !== 13'h041 || obs_wbrd[0] !== 5'd3) begin n_err++; $display("FAIL add_wb_lat1 got mem=%h wb=%h/%0d want 041 041/3", obs_mem[0], obs_wb[0], obs_wbrd[0]); end
        n_vec++; if (obs_mem[1] !== 13'h041 || obs_wb[1] !== 13'h0) begin n_err++; $display("FAIL add_mem_lat3 got mem=%h wb=%h want 041 000", obs_mem[1], obs_wb[1]); end
      end
      if (c == 3) begin
        n_vec++; if (obs_wb[1] !== 13'h041 || obs_wbrd[1] !== 5'd3) begin n_err++; $display("FAIL add_wb_lat3 got %h/%0d want 041/3", obs_wb[1], obs_wbrd[1]); end
      end
    end
  endtask

  task automatic test_load_use();
    int hcnt [2];
    hcnt[0] = 0; hcnt[1] = 0;
    drive(1'b1, LW5, 1'b0, 1'b0);
    clk_step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ADD6, 1'b0, 1'b0);
      snap();
      for (int d = 0; d < 2; d++) hcnt[d] += int'(obs_haz[d]);
      clk_step();
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (obs_ex[d] !== ((i < lat_of(d)) ? 13'h000 : 13'h041)) begin
          n_err++; $display("FAIL loaduse_ex d%0d step%0d got %h want %h", d, i, obs_ex[d], (i < lat_of(d)) ? 13'h000 : 13'h041);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (hcnt[d] != lat_of(d)) begin n_err++; $display("FAIL loaduse_hazcycles d%0d got %0d want %0d", d, hcnt[d], lat_of(d)); end
    end
  endtask

  task automatic test_x0();
    drive(1'b1, LW0, 1'b0, 1'b0);
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h195 || obs_exrd[d] !== 5'd0) begin n_err++; $display("FAIL x0_ex d%0d got %h/%0d want 195/0", d, obs_ex[d], obs_exrd[d]); end
    end
    drive(1'b1, ADD60, 1'b0, 1'b0);
    snap();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_haz[d] !== 1'b0) begin n_err++; $display("FAIL x0_haz d%0d got %b want 0", d, obs_haz[d]); end
    end
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h041 || obs_exrd[d] !== 5'd6) begin n_err++; $display("FAIL x0_next d%0d got %h/%0d want 041/6", d, obs_ex[d], obs_exrd[d]); end
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, ADD3, 1'b0, 1'b0);
    clk_step();
    drive(1'b1, JALR1, 1'b1, 1'b1);
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h0 || obs_exrd[d] !== 5'd0) begin n_err++; $display("FAIL flst_ex d%0d got %h/%0d want 0/0", d, obs_ex[d], obs_exrd[d]); end
      n_vec++; if (obs_mem[d] !== 13'h041 || obs_memrd[d] !== 5'd3) begin n_err++; $display("FAIL flst_mem d%0d got %h/%0d want 041/3", d, obs_mem[d], obs_memrd[d]); end
    end
    drive(1'b1, JALR1, 1'b1, 1'b0);
    clk_step();
    n_vec++; if (obs_ex[0] !== 13'h0) begin n_err++; $display("FAIL stall_only_ex got %h want 0", obs_ex[0]); end
    drive(1'b1, JALR1, 1'b0, 1'b1);
    clk_step();
    n_vec++; if (obs_ex[1] !== 13'h0) begin n_err++; $display("FAIL flush_only_ex got %h want 0", obs_ex[1]); end
    drive(1'b1, JALR1, 1'b0, 1'b0);
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h13E1 || obs_exrd[d] !== 5'd1) begin n_err++; $display("FAIL jalr_ex d%0d got %h/%0d want 13e1/1", d, obs_ex[d], obs_exrd[d]); end
    end
    drive(1'b1, LW5, 1'b0, 1'b0);
    clk_step();
    drive(1'b1, ADD6, 1'b0, 1'b1);
    snap();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_haz[d] !== 1'b1) begin n_err++; $display("FAIL flush_haz d%0d got %b want 1", d, obs_haz[d]); end
    end
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h0) begin n_err++; $display("FAIL flush_haz_ex d%0d got %h want 0", d, obs_ex[d]); end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) clk_step();
  endtask

  task automatic test_illegal();
    drive(1'b1, ILL7F, 1'b0, 1'b0);
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h0 || obs_ill[d] !== TRAP) begin n_err++; $display("FAIL illegal_set d%0d got ex=%h ill=%b want 0/%b", d, obs_ex[d], obs_ill[d], TRAP); end
    end
    drive(1'b1, ADD3, 1'b0, 1'b0);
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ill[d] !== 1'b0 || obs_ex[d] !== 13'h041) begin n_err++; $display("FAIL illegal_clear d%0d got ill=%b ex=%h want 0/041", d, obs_ill[d], obs_ex[d]); end
    end
    drive(1'b1, 32'h00000031, 1'b0, 1'b1);
    clk_step();
    n_vec++; if (obs_ill[0] !== 1'b0) begin n_err++; $display("FAIL illegal_flushed got %b want 0", obs_ill[0]); end
    drive(1'b1, 32'h00000031, 1'b0, 1'b0);
    clk_step();
    n_vec++; if (obs_ill[1] !== TRAP || obs_ex[1] !== 13'h0) begin n_err++; $display("FAIL illegal_lowbits got ill=%b ex=%h want %b/0", obs_ill[1], obs_ex[1], TRAP); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, ADD3, 1'b0, 1'b0);
    clk_step();
    drive(1'b1, LW5, 1'b0, 1'b0);
    clk_step();
    drive(1'b1, ADD6, 1'b0, 1'b0);
    snap();
    n_vec++; if (obs_haz[1] !== 1'b1) begin n_err++; $display("FAIL arst_pre_haz got %b want 1", obs_haz[1]); end
    rst_n = 1'b0;
    #1;
    snap();
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (obs_ex[d] !== 13'h0 || obs_mem[d] !== 13'h0 || obs_wb[d] !== 13'h0 || obs_exrd[d] !== 5'd0 ||
          obs_memrd[d] !== 5'd0 || obs_wbrd[d] !== 5'd0 || obs_haz[d] !== 1'b0 || obs_ill[d] !== 1'b0) begin
        n_err++; $display("FAIL arst_clear d%0d got ex=%h mem=%h wb=%h haz=%b ill=%b want all 0", d, obs_ex[d], obs_mem[d], obs_wb[d], obs_haz[d], obs_ill[d]);
      end
    end
    model_clear();
    #1 rst_n = 1'b1;
    clk_step();
    for (int d = 0; d < 2; d++) begin
      n_vec++; if (obs_ex[d] !== 13'h041 || obs_exrd[d] !== 5'd6) begin n_err++; $display("FAIL arst_first d%0d got %h/%0d want 041/6", d, obs_ex[d], obs_exrd[d]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [6:0]  op;
    int          r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: op = 7'b0110011;  1: op = 7'b0000011;  2: op = 7'b0100011;
        3: op = 7'b1100011;  4: op = 7'b0010011;  5: op = 7'b1101111;
        6: op = 7'b1100111;  7: op = 7'b0010111;  8: op = 7'b0110111;
        9: op = 7'h7F;       10: op = 7'($urandom_range(0, 127));
        default: op = 7'b0000011;
      endcase
      ins = $urandom;
      ins[6:0]   = op;
      ins[11:7]  = 5'($urandom_range(0, 3));
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive(($urandom_range(0, 4) != 0), ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
      snap();
      for (int d = 0; d < 2; d++) begin
        n_vec++; if (obs_haz[d] !== ref_haz(d, cur_v, cur_ins)) begin n_err++; $display("FAIL rnd_haz d%0d cyc%0d got %b want %b", d, cyc, obs_haz[d], ref_haz(d, cur_v, cur_ins)); end
      end
      clk_step();
      for (int d = 0; d < 2; d++) begin
        n_vec++; if (obs_ex[d] !== hc[d][0] || obs_exrd[d] !== hr[d][0]) begin n_err++; $display("FAIL rnd_ex d%0d cyc%0d got %h/%0d want %h/%0d", d, cyc, obs_ex[d], obs_exrd[d], hc[d][0], hr[d][0]); end
        n_vec++; if (obs_mem[d] !== hc[d][1] || obs_memrd[d] !== hr[d][1]) begin n_err++; $display("FAIL rnd_mem d%0d cyc%0d got %h/%0d want %h/%0d", d, cyc, obs_mem[d], obs_memrd[d], hc[d][1], hr[d][1]); end
        n_vec++; if (obs_wb[d] !== hc[d][lat_of(d)] || obs_wbrd[d] !== hr[d][lat_of(d)]) begin n_err++; $display("FAIL rnd_wb d%0d cyc%0d got %h/%0d want %h/%0d", d, cyc, obs_wb[d], obs_wbrd[d], hc[d][lat_of(d)], hr[d][lat_of(d)]); end
        n_vec++; if (obs_ill[d] !== exp_ill[d]) begin n_err++; $display("FAIL rnd_ill d%0d cyc%0d got %b want %b", d, cyc, obs_ill[d], exp_ill[d]); end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_add();
    test_load_use();
    test_x0();
    test_flush_stall();
    test_illegal();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
